// File: rtl/gf_div_seq.sv
// Sequential GF(2^N) divider: Z = A * B^-1, with B^-1 = B^(2^N-2) built by repeated squaring.
// Ready/valid on both sides; one operation in flight, results held until the consumer takes them.
module gf_div_seq #(
   parameter int         N    = 3,
   parameter logic [N:0] POLY = 4'b1101
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Z,
   output logic         div_by_zero
);

   localparam int CW = (N > 2) ? $clog2(N - 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);
   localparam logic [N-1:0]  GF_ONE   = {{(N-1){1'b0}}, 1'b1};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ITER  = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Shift-and-add multiply; the running multiplicand is reduced by POLY at every shift.
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N-1:0] p;
      logic [N-1:0] t;
      p = '0;
      t = x;
      for (int i = 0; i < N; i++) begin
         if (y[i]) p = p ^ t;
         t = t[N-1] ? ((t << 1) ^ POLY[N-1:0]) : (t << 1);
      end
      return p;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  sq_q, sq_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dbz_q, dbz_d;
   logic [N-1:0]  z_q, z_d;
   logic          div_by_zero_q, div_by_zero_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  sq_sq;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      a_d           = a_q;
      sq_d          = sq_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      dbz_d         = dbz_q;
      z_d           = z_q;
      div_by_zero_d = div_by_zero_q;
      out_valid_d   = out_valid_q;
      sq_sq         = gf_mul(sq_q, sq_q);

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               sq_d    = B;
               acc_d   = GF_ONE;
               cnt_d   = '0;
               dbz_d   = (B == '0);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            // acc collects B^(2^i) for i = 1..N-1, i.e. B^(2^N-2) = B^-1 after the last pass.
            sq_d  = sq_sq;
            acc_d = gf_mul(acc_q, sq_sq);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_FINAL;
         end
         S_FINAL: begin
            z_d           = dbz_q ? '0 : gf_mul(a_q, acc_q);
            div_by_zero_d = dbz_q;
            out_valid_d   = 1'b1;
            state_d       = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= S_IDLE;
         a_q           <= '0;
         sq_q          <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         dbz_q         <= 1'b0;
         z_q           <= '0;
         div_by_zero_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         sq_q          <= sq_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         dbz_q         <= dbz_d;
         z_q           <= z_d;
         div_by_zero_q <= div_by_zero_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = out_valid_q;
   assign Z           = z_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_gf_div_seq.sv
// Directed bench for gf_div_seq at N=3, POLY=x^3+x^2+1 (a=010, a^2=100, a^3=101, a^4=111, a^5=011, a^6=110).
module tb_gf_div_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] A = 3'd0;
   logic [2:0] B = 3'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [2:0] Z;
   logic       div_by_zero;

   int checks   = 0;
   int failures = 0;

   gf_div_seq #(.N(3), .POLY(4'b1101)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Z          (Z),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Full carry-less product, then polynomial long division by 1101.
   function automatic logic [2:0] ref_mul(input logic [2:0] x, input logic [2:0] y);
      logic [4:0] prod;
      logic [4:0] pmod;
      prod = 5'd0;
      pmod = 5'b01101;
      for (int i = 0; i < 3; i++)
         if (y[i]) prod = prod ^ (5'(x) << i);
      for (int i = 4; i >= 3; i--)
         if (prod[i]) prod = prod ^ (pmod << (i - 3));
      return prod[2:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one operand pair, scrambles the inputs after the accepting edge, and waits for the result.
   // Latency counts the accepting edge as edge 1; the result must be visible after edge 4.
   task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] exp_z, input logic exp_dbz, input string tag);
      int wait_cnt;
      int lat;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
         step();
         wait_cnt++;
      end
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      A = a;
      B = b;
      step();
      in_valid = 1'b0;
      A = ~a;
      B = ~b;
      lat = 1;
      while (!out_valid && lat < 12) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " Z"}, 32'(Z), 32'(exp_z));
      check({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
   endtask

   initial begin
      // 1. reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst Z", 32'(Z), 32'd0);
      check("rst dbz", 32'(div_by_zero), 32'd0);

      // 2. basic division a^3 / a = a^2
      out_ready = 1'b1;
      do_op(3'b101, 3'b010, 3'b100, 1'b0, "basic");
      step();
      check("basic release out_valid", 32'(out_valid), 32'd0);
      check("basic release in_ready", 32'(in_ready), 32'd1);

      // 3. inverse sweep
      do_op(3'b001, 3'b101, 3'b111, 1'b0, "inv101");
      check("inv101 Z*B", 32'(ref_mul(Z, 3'b101)), 32'd1);
      do_op(3'b001, 3'b111, 3'b101, 1'b0, "inv111");
      check("inv111 Z*B", 32'(ref_mul(Z, 3'b111)), 32'd1);
      do_op(3'b001, 3'b110, 3'b010, 1'b0, "inv110");
      check("inv110 Z*B", 32'(ref_mul(Z, 3'b110)), 32'd1);
      do_op(3'b001, 3'b001, 3'b001, 1'b0, "inv001");
      check("inv001 Z*B", 32'(ref_mul(Z, 3'b001)), 32'd1);

      // 4. divide by zero, then zero dividend
      do_op(3'b011, 3'b000, 3'b000, 1'b1, "b_zero");
      do_op(3'b000, 3'b011, 3'b000, 1'b0, "a_zero");

      // 5. backpressure: a^5 / a^6 = a^-1 = a^6
      step();
      out_ready = 1'b0;
      do_op(3'b011, 3'b110, 3'b110, 1'b0, "bp");
      in_valid = 1'b1;
      A = 3'b001;
      B = 3'b001;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp hold Z", 32'(Z), 32'b110);
         check("bp hold out_valid", 32'(out_valid), 32'd1);
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) step();
      check("bp ignored op not queued", 32'(out_valid), 32'd0);

      // 6. reset during ITER aborts the operation
      in_valid = 1'b1;
      A = 3'b011;
      B = 3'b010;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst in_ready", 32'(in_ready), 32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst Z", 32'(Z), 32'd0);
      for (int i = 0; i < 6; i++) step();
      check("midrst no result", 32'(out_valid), 32'd0);
      do_op(3'b001, 3'b010, 3'b110, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
